fetch_hazard_ctrl: RTL and testbench

//  Sequencer for the IF stage and IF/ID latch: stalls the PC and IF/ID on load-use hazards
//  and instruction-memory wait, redirects the PC on a taken branch from EX/MEM, and flushes

---
 rtl/fetch_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_hazard_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl
//   Sequencer for the IF stage and the IF/ID latch. It stalls the PC and IF/ID
//   on load-use hazards and on instruction-memory wait. It redirects the PC on a
//   taken branch or jump resolved in EX/MEM and flushes wrong-path instructions.
//   A redirect that arrives while memory is not ready is held until the fetch
//   can complete. Saturating counters report stall cycles and applied redirects.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   ex_mem_pc_src   taken branch/jump resolved in EX/MEM
//   ex_mem_npc      redirect target
//   imem_ready      instruction memory has valid data this cycle
//   id_ex_mem_read  instruction in ID/EX is a load
//   id_ex_rt        load destination register
//   if_id_rs/rt     source registers of the instruction in IF/ID
//   pc_we, pc_sel   PC load enable and mux select (0: PC+1, 1: pc_target)
//   pc_target       redirect address (zero whenever pc_sel=0)
//   if_id_we        IF/ID latch enable
//   if_id_flush     IF/ID loads a NOP this edge
//   id_ex_bubble    ID/EX control fields forced to zero this edge
//   stall_cnt       cycles with pc_we=0, saturating
//   flush_cnt       redirects applied, saturating
//   dbg_state       current sequencer state (RUN/LU_STALL/MEM_WAIT)
//
// Handshake: imem_ready acts as the fetch "ready". A fetch completes, and the
// PC may advance or be redirected, only in a cycle where imem_ready=1. In any
// cycle with imem_ready=0 the PC holds and a NOP is fed into ID.

module fetch_hazard_ctrl #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_pc_src,
    input  logic [ADDR_W-1:0] ex_mem_npc,
    input  logic              imem_ready,
    input  logic              id_ex_mem_read,
    input  logic [REG_W-1:0]  id_ex_rt,
    input  logic [REG_W-1:0]  if_id_rs,
    input  logic [REG_W-1:0]  if_id_rt,
    output logic              pc_we,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              if_id_we,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              pend_vld_q, pend_vld_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              lu_haz;
    logic              redir;
    logic [ADDR_W-1:0] redir_target;
    logic              stall_inc;
    logic              flush_inc;

    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign lu_haz = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // A live redirect from EX/MEM is newer than anything pending.
    assign redir        = ex_mem_pc_src || pend_vld_q;
    assign redir_target = ex_mem_pc_src ? ex_mem_npc : pend_pc_q;

    always_comb begin
        pc_we        = 1'b1;
        pc_sel       = 1'b0;
        pc_target    = '0;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = RUN;
        pend_vld_d   = pend_vld_q;
        pend_pc_d    = pend_pc_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (imem_ready && redir) begin
            // Redirect wins over everything, including a load-use stall.
            pc_sel       = 1'b1;
            pc_target    = redir_target;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pend_vld_d   = 1'b0;
            flush_inc    = 1'b1;
            state_d      = RUN;
        end else if (!imem_ready) begin
            pc_we        = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = lu_haz;
            if (ex_mem_pc_src) begin
                pend_vld_d = 1'b1;
                pend_pc_d  = ex_mem_npc;
            end
            stall_inc = 1'b1;
            state_d   = MEM_WAIT;
        end else if ((state_q == RUN) && lu_haz) begin
            // One-cycle stall; in LU_STALL the hazard is ignored so the
            // dependent instruction issues on the following cycle.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
            state_d      = LU_STALL;
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pend_vld_q  <= 1'b0;
            pend_pc_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_pc_q   <= pend_pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Testbench for fetch_hazard_ctrl: directed vectors with hand-computed
// expectations pushed into queues; a negedge monitor pops and compares.

module tb_fetch_hazard_ctrl;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 8;
  localparam int OW     = ADDR_W + 5;

  logic              clk;
  logic              rst;
  logic              ex_mem_pc_src;
  logic [ADDR_W-1:0] ex_mem_npc;
  logic              imem_ready;
  logic              id_ex_mem_read;
  logic [REG_W-1:0]  id_ex_rt;
  logic [REG_W-1:0]  if_id_rs;
  logic [REG_W-1:0]  if_id_rt;
  logic              pc_we;
  logic              pc_sel;
  logic [ADDR_W-1:0] pc_target;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [1:0]        dbg_state;

  fetch_hazard_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_pc_src(ex_mem_pc_src), .ex_mem_npc(ex_mem_npc),
    .imem_ready(imem_ready), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
    .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [OW-1:0]      exp_q[$];
  string              tag_q[$];
  logic [2*CNT_W-1:0] cnt_q[$];
  string              ctag_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [OW-1:0] mk(input logic we, input logic sel,
                                       input logic [ADDR_W-1:0] tgt,
                                       input logic ifwe, input logic fl,
                                       input logic bub);
    return {we, sel, tgt, ifwe, fl, bub};
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [OW-1:0]      e;
    logic [OW-1:0]      got;
    logic [2*CNT_W-1:0] ce;
    string              t;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {pc_we, pc_sel, pc_target, if_id_we, if_id_flush, id_ex_bubble};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: {pc_we,pc_sel,pc_target,if_id_we,flush,bubble} got %h expected %h",
                 t, got, e);
      end
    end
    if (cnt_q.size() > 0) begin
      ce = cnt_q.pop_front();
      t  = ctag_q.pop_front();
      checks++;
      if ({stall_cnt, flush_cnt} !== ce) begin
        failures++;
        $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d expected stall_cnt=%0d flush_cnt=%0d",
                 t, stall_cnt, flush_cnt, ce[2*CNT_W-1:CNT_W], ce[CNT_W-1:0]);
      end
    end
  end

  // driver tasks
  task automatic step(input string tag, input logic r, input logic src,
                      input logic [ADDR_W-1:0] npc, input logic rdy,
                      input logic mr, input logic [REG_W-1:0] ert,
                      input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic [OW-1:0] e);
    rst            = r;
    ex_mem_pc_src  = src;
    ex_mem_npc     = npc;
    imem_ready     = rdy;
    id_ex_mem_read = mr;
    id_ex_rt       = ert;
    if_id_rs       = rs;
    if_id_rt       = rt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic step_idle(input string tag, input logic [OW-1:0] e);
    step(tag, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0, e);
  endtask

  task automatic do_reset(input string tag);
    step(tag, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0, mk(1, 0, '0, 1, 1, 1));
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] s,
                           input logic [CNT_W-1:0] f);
    cnt_q.push_back({s, f});
    ctag_q.push_back(tag);
  endtask

  logic [OW-1:0] n_out, lu_out, w_out, wlu_out;

  initial begin
    n_out   = mk(1, 0, '0, 1, 0, 0);
    lu_out  = mk(0, 0, '0, 0, 0, 1);
    w_out   = mk(0, 0, '0, 1, 1, 0);
    wlu_out = mk(0, 0, '0, 1, 1, 1);

    rst = 1'b1; ex_mem_pc_src = 1'b0; ex_mem_npc = '0; imem_ready = 1'b1;
    id_ex_mem_read = 1'b0; id_ex_rt = '0; if_id_rs = '0; if_id_rt = '0;
    @(posedge clk);
    #1;

    // 1: reset then free run
    do_reset("rst_a");
    do_reset("rst_b");
    for (int i = 0; i < 3; i++) step_idle("run", n_out);
    check_cnt("run_cnt", 0, 0);

    // 2: load-use on rs, one cycle only even with inputs held
    step("lu_rs", 0, 0, '0, 1, 1, 5'd5, 5'd5, 5'd0, lu_out);
    step("lu_held", 0, 0, '0, 1, 1, 5'd5, 5'd5, 5'd0, n_out);
    check_cnt("lu_cnt", 1, 0);
    step("lu_r0", 0, 0, '0, 1, 1, 5'd0, 5'd0, 5'd0, n_out);
    step("lu_noload", 0, 0, '0, 1, 0, 5'd6, 5'd6, 5'd6, n_out);
    step("lu_rt", 0, 0, '0, 1, 1, 5'd7, 5'd1, 5'd7, lu_out);
    step_idle("lu_rt_after", n_out);
    check_cnt("lu_cnt2", 2, 0);

    // 3: redirect beats load-use
    do_reset("rst3");
    step("redir_lu", 0, 1, 32'h10, 1, 1, 5'd5, 5'd5, 5'd0, mk(1, 1, 32'h10, 1, 1, 1));
    check_cnt("redir_cnt", 0, 1);
    step_idle("redir_after", n_out);

    // 4: memory wait with newer pending redirect overwriting older
    do_reset("rst4");
    step("wait1", 0, 1, 32'h08, 0, 0, '0, '0, '0, w_out);
    step("wait2", 0, 1, 32'h0C, 0, 0, '0, '0, '0, w_out);
    step("wait3", 0, 0, '0, 0, 0, '0, '0, '0, w_out);
    step_idle("pend_apply", mk(1, 1, 32'h0C, 1, 1, 1));
    check_cnt("wait_cnt", 3, 1);
    step_idle("pend_clear", n_out);
    step("wait_lu", 0, 0, '0, 0, 1, 5'd3, 5'd3, 5'd0, wlu_out);
    step("wait_exit_lu", 0, 0, '0, 1, 1, 5'd3, 5'd3, 5'd0, n_out);
    step("wait_src", 0, 1, 32'h20, 0, 0, '0, '0, '0, w_out);
    step("live_over_pend", 0, 1, 32'h30, 1, 0, '0, '0, '0, mk(1, 1, 32'h30, 1, 1, 1));
    step_idle("after_live", n_out);
    check_cnt("wait_cnt2", 5, 2);

    // 5: reset discards a pending redirect
    do_reset("rst5");
    step("wait_pend", 0, 1, 32'h44, 0, 0, '0, '0, '0, w_out);
    step("rst_in_wait", 1, 0, '0, 0, 0, '0, '0, '0, mk(1, 0, '0, 1, 1, 1));
    step_idle("no_redir", n_out);
    check_cnt("rst_cnt", 0, 0);

    // 6: stall counter saturation
    do_reset("rst6");
    for (int i = 0; i < (1 << CNT_W) + 5; i++)
      step("sat_wait", 0, 0, '0, 0, 0, '0, '0, '0, w_out);
    check_cnt("sat_cnt", '1, 0);
    step_idle("sat_exit", n_out);
    check_cnt("sat_hold", '1, 0);

    @(posedge clk);
    #1;
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0 || cnt_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d output and %0d counter expectations left, expected 0",
               exp_q.size(), cnt_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
